// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave that snapshots a fabric word for the PowerPC, with a sticky new-data
// flag, a saturating overrun counter and a PPC-controlled capture freeze.
module opb_register_simulink2ppc_snap #(
   parameter logic [31:0] C_BASEADDR   = 32'h01010500,
   parameter logic [31:0] C_HIGHADDR   = 32'h010105FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter string       C_FAMILY     = "virtex6"
) (
   input  logic        OPB_Clk,
   input  logic        OPB_Rst,
   input  logic [0:31] OPB_ABus,
   input  logic [0:3]  OPB_BE,
   input  logic [0:31] OPB_DBus,
   input  logic        OPB_RNW,
   input  logic        OPB_select,
   input  logic        OPB_seqAddr,
   output logic [0:31] Sl_DBus,
   output logic        Sl_xferAck,
   output logic        Sl_errAck,
   output logic        Sl_retry,
   output logic        Sl_toutSup,
   input  logic [31:0] user_data_in,
   input  logic        user_valid,
   output logic        user_frozen
);

   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_RSVD   = 2'd3
   } reg_sel_e;

   localparam bit unused_family = (C_FAMILY == "");

   // Value assignment maps OPB bit 0 onto numeric bit 31, so no explicit reversal is needed.
   logic [C_OPB_AWIDTH-1:0] addr;
   logic [C_OPB_DWIDTH-1:0] wdata;
   assign addr  = OPB_ABus;
   assign wdata = OPB_DBus;

   logic [C_OPB_DWIDTH-1:0] snap_q, snap_d;
   logic [C_OPB_DWIDTH-1:0] dbus_q, dbus_d;
   logic [15:0]             count_q, count_d;
   logic                    new_flag_q, new_flag_d;
   logic                    freeze_q, freeze_d;
   logic                    ack_q, ack_d;

   logic                    hit, start, capture;
   reg_sel_e                sel;
   logic [C_OPB_DWIDTH-1:0] rdata;

   assign hit     = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
   assign start   = hit && !ack_q && !OPB_Rst;
   assign sel     = reg_sel_e'(addr[3:2]);
   assign capture = user_valid && !freeze_q;

   always_comb begin
      unique case (sel)
         REG_DATA:   rdata = snap_q;
         REG_STATUS: rdata = {new_flag_q, 15'd0, count_q};
         REG_CTRL:   rdata = {31'd0, freeze_q};
         default:    rdata = '0;
      endcase
   end

   // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latch).
   always_comb begin
      snap_d     = snap_q;
      new_flag_d = new_flag_q;
      count_d    = count_q;
      freeze_d   = freeze_q;
      ack_d      = start;
      dbus_d     = (start && OPB_RNW) ? rdata : '0;

      if (start && OPB_RNW && sel == REG_DATA)
         new_flag_d = 1'b0;

      // A capture overrides the read-clear; overrun looks at the flag as it was before this edge.
      if (capture) begin
         snap_d     = user_data_in;
         new_flag_d = 1'b1;
         if (new_flag_q && count_q != 16'hFFFF)
            count_d = count_q + 16'd1;
      end

      if (start && !OPB_RNW && sel == REG_STATUS)
         count_d = '0;

      if (start && !OPB_RNW && sel == REG_CTRL && OPB_BE[3])
         freeze_d = wdata[0];
   end

   // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         snap_q     <= '0;
         new_flag_q <= 1'b0;
         count_q    <= '0;
         freeze_q   <= 1'b0;
         ack_q      <= 1'b0;
         dbus_q     <= '0;
      end else begin
         snap_q     <= snap_d;
         new_flag_q <= new_flag_d;
         count_q    <= count_d;
         freeze_q   <= freeze_d;
         ack_q      <= ack_d;
         dbus_q     <= dbus_d;
      end
   end

   assign Sl_DBus     = dbus_q;
   assign Sl_xferAck  = ack_q;
   assign Sl_errAck   = 1'b0;
   assign Sl_retry    = 1'b0;
   assign Sl_toutSup  = 1'b0;
   assign user_frozen = freeze_q;

   logic unused_inputs;
   assign unused_inputs = &{1'b0, OPB_seqAddr, OPB_BE[0:2], wdata[C_OPB_DWIDTH-1:1], unused_family};

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Self-checking bench: directed scenarios plus random bus/capture traffic
// compared against a transaction-level model of the snapshot register.
module tb_opb_register_simulink2ppc_snap;

   localparam logic [31:0] BASE = 32'h01010500;
   localparam logic [31:0] HIGH = 32'h010105FF;

   logic        clk = 1'b0;
   logic        rst;
   logic [0:31] abus, dbus;
   logic [0:3]  be;
   logic        rnw, sel, seqaddr;
   logic [31:0] ud;
   logic        uv;
   logic [0:31] sl_dbus;
   logic        ack, errack, retry, toutsup, frozen;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   opb_register_simulink2ppc_snap dut (
      .OPB_Clk      (clk),
      .OPB_Rst      (rst),
      .OPB_ABus     (abus),
      .OPB_BE       (be),
      .OPB_DBus     (dbus),
      .OPB_RNW      (rnw),
      .OPB_select   (sel),
      .OPB_seqAddr  (seqaddr),
      .Sl_DBus      (sl_dbus),
      .Sl_xferAck   (ack),
      .Sl_errAck    (errack),
      .Sl_retry     (retry),
      .Sl_toutSup   (toutsup),
      .user_data_in (ud),
      .user_valid   (uv),
      .user_frozen  (frozen)
   );

   // Reference model: plain variables updated per transaction.
   logic [31:0] m_snap;
   bit          m_new;
   int          m_cnt;
   bit          m_frz;

   function automatic void m_reset();
      m_snap = '0; m_new = 0; m_cnt = 0; m_frz = 0;
   endfunction

   function automatic bit m_capture(input logic [31:0] w);
      if (m_frz) return 0;
      if (m_new && m_cnt < 65535) m_cnt++;
      m_new  = 1;
      m_snap = w;
      return 1;
   endfunction

   function automatic logic [31:0] m_read(input logic [1:0] off);
      case (off)
         2'd0:    return m_snap;
         2'd1:    return {m_new, 15'd0, m_cnt[15:0]};
         2'd2:    return {31'd0, m_frz};
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One complete transfer. b is written in OPB order, so BE[3] is b[0].
   task automatic bus(input bit rd, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] wd, input bit do_uv, input logic [31:0] uw,
                      output logic [31:0] rdat);
      logic [31:0] exp;
      logic [1:0]  off;
      bit          capt;
      @(negedge clk);
      abus = a; be = b; dbus = wd; rnw = rd; sel = 1'b1; uv = do_uv; ud = uw;
      off = a[3:2];
      exp = rd ? m_read(off) : 32'd0;
      @(posedge clk);
      capt = do_uv ? m_capture(uw) : 1'b0;
      if (rd && off == 2'd0 && !capt) m_new = 0;
      if (!rd && off == 2'd1) m_cnt = 0;
      if (!rd && off == 2'd2 && b[0]) m_frz = wd[0];
      #1;
      check("xfer_ack", ack, 1);
      check(rd ? "read_data" : "write_dbus", sl_dbus, exp);
      rdat = sl_dbus;
      sel = 1'b0; uv = 1'b0;
      @(posedge clk); #1;
      check("ack_single", ack, 0);
      check("dbus_idle", sl_dbus, 0);
   endtask

   task automatic pulse(input logic [31:0] w);
      @(negedge clk);
      uv = 1'b1; ud = w;
      @(posedge clk);
      void'(m_capture(w));
      #1 uv = 1'b0;
   endtask

   logic [31:0] r;

   initial begin
      rst = 1'b1; abus = '0; be = '0; dbus = '0; rnw = 1'b0; sel = 1'b0;
      seqaddr = 1'b0; ud = '0; uv = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_ack", ack, 0);
      check("rst_dbus", sl_dbus, 0);
      check("rst_frozen", frozen, 0);
      check("tied_zero", {29'd0, errack, retry, toutsup}, 0);
      rst = 1'b0;

      // Reset state via the bus.
      bus(1, BASE + 0, 4'hF, 0, 0, 0, r); check("rst_data", r, 32'h0);
      bus(1, BASE + 4, 4'hF, 0, 0, 0, r); check("rst_status", r, 32'h0);
      bus(1, BASE + 8, 4'hF, 0, 0, 0, r); check("rst_ctrl", r, 32'h0);

      // Capture and read.
      pulse(32'hDEADBEEF);
      bus(1, BASE + 4, 4'hF, 0, 0, 0, r); check("cap_status", r, 32'h80000000);
      bus(1, BASE + 0, 4'hF, 0, 0, 0, r); check("cap_data", r, 32'hDEADBEEF);
      bus(1, BASE + 4, 4'hF, 0, 0, 0, r); check("cap_cleared", r, 32'h0);

      // Overrun.
      pulse(32'h1); pulse(32'h2); pulse(32'h3);
      bus(1, BASE + 4, 4'hF, 0, 0, 0, r); check("ovr_status", r, 32'h80000002);
      bus(1, BASE + 0, 4'hF, 0, 0, 0, r); check("ovr_data", r, 32'h3);
      pulse(32'h4); pulse(32'h5);
      bus(0, BASE + 4, 4'h0, 32'hFFFFFFFF, 0, 0, r);
      bus(1, BASE + 4, 4'hF, 0, 0, 0, r); check("ovr_clear", r, 32'h80000000);
      // Clear wins over a simultaneous overrun increment.
      bus(0, BASE + 4, 4'hF, 0, 1, 32'h6, r);
      bus(1, BASE + 4, 4'hF, 0, 0, 0, r); check("ovr_clear_wins", r, 32'h80000000);

      // Saturation.
      @(negedge clk);
      uv = 1'b1;
      repeat (70000) begin
         ud = $urandom;
         @(posedge clk);
         void'(m_capture(ud));
         @(negedge clk);
      end
      uv = 1'b0;
      bus(1, BASE + 4, 4'hF, 0, 0, 0, r); check("sat_status", r, 32'h8000FFFF);
      bus(0, BASE + 4, 4'hF, 0, 0, 0, r);
      bus(1, BASE + 0, 4'hF, 0, 0, 0, r);

      // Freeze.
      bus(0, BASE + 8, 4'hF, 32'h1, 0, 0, r);
      #1 check("frozen_set", frozen, 1);
      pulse(32'h55AA55AA);
      bus(1, BASE + 4, 4'hF, 0, 0, 0, r); check("frz_new_kept", r, 32'h0);
      bus(1, BASE + 0, 4'hF, 0, 0, 0, r); check("frz_data_kept", r, m_snap);
      bus(0, BASE + 8, 4'b1110, 32'h0, 0, 0, r);
      #1 check("frz_be_masked", frozen, 1);
      bus(0, BASE + 8, 4'hF, 32'h0, 0, 0, r);
      #1 check("frozen_clr", frozen, 0);
      pulse(32'h12345678);
      bus(1, BASE + 0, 4'hF, 0, 0, 0, r); check("frz_resume", r, 32'h12345678);

      // Collision: capture on the edge that acks a DATA read.
      pulse(32'hA5A5A5A5);
      bus(1, BASE + 0, 4'hF, 0, 1, 32'hCAFEF00D, r); check("col_prev", r, 32'hA5A5A5A5);
      bus(1, BASE + 4, 4'hF, 0, 0, 0, r); check("col_new", {31'd0, r[31]}, 32'h1);
      bus(1, BASE + 0, 4'hF, 0, 0, 0, r); check("col_data", r, 32'hCAFEF00D);

      // Out-of-window select.
      @(negedge clk);
      abus = HIGH + 4; rnw = 1'b1; sel = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         check("oow_ack", ack, 0);
         check("oow_dbus", sl_dbus, 0);
      end
      sel = 1'b0;

      // Select held four cycles: acks on alternate cycles.
      pulse(32'h0BADF00D);
      @(negedge clk);
      abus = BASE; rnw = 1'b1; sel = 1'b1;
      for (int k = 0; k < 4; k++) begin
         logic [31:0] exp;
         exp = (k % 2 == 0) ? m_read(2'd0) : 32'd0;
         @(posedge clk);
         if (k % 2 == 0) m_new = 0;
         #1;
         check("hold_ack", ack, (k % 2 == 0) ? 1 : 0);
         check("hold_dbus", sl_dbus, exp);
      end
      sel = 1'b0;
      bus(1, BASE + 4, 4'hF, 0, 0, 0, r); check("hold_status", r, m_read(2'd1));

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         int          op;
         logic [31:0] a;
         op = $urandom_range(0, 3);
         a  = BASE | ($urandom & 32'hFF);
         case (op)
            0: pulse($urandom);
            1: bus(1, a, 4'hF, 0, $urandom_range(0, 1), $urandom, r);
            2: bus(0, a, 4'($urandom), $urandom, $urandom_range(0, 1), $urandom, r);
            default: begin
               @(negedge clk);
               @(posedge clk); #1;
               check("rnd_frozen", frozen, m_frz);
            end
         endcase
      end
      for (int o = 0; o < 4; o++) bus(1, BASE + 32'(o * 4), 4'hF, 0, 0, 0, r);

      // Reset asserted during the hit cycle.
      pulse(32'h77777777);
      @(negedge clk);
      abus = BASE; rnw = 1'b1; sel = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      check("rst_hit_ack0", ack, 0);
      rst = 1'b0; sel = 1'b0;
      m_reset();
      @(posedge clk); #1;
      check("rst_hit_ack1", ack, 0);
      check("rst_hit_frozen", frozen, 0);
      bus(1, BASE + 4, 4'hF, 0, 0, 0, r); check("rst_hit_status", r, 32'h0);
      bus(1, BASE + 0, 4'hF, 0, 0, 0, r); check("rst_hit_data", r, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
